// File: rtl/mips_multicycle_control_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath.
// master = controller side, slave = datapath/instruction register side.
interface mips_multicycle_control_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] alu_result;
  logic        mem_ready;
  logic        pc_en;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        iord;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_src;
  logic [2:0]  alu_control;
  logic        illegal_op;
  logic [3:0]  state;

  modport master (
    input  opcode, funct, alu_result, mem_ready,
    output pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control, illegal_op, state
  );

  modport slave (
    output opcode, funct, alu_result, mem_ready,
    input  pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM: decodes opcode/funct and sequences the datapath.
// state  | meaning
// FETCH  | read instruction, PC+4     DECODE | decode, precompute branch target
// MEMADR | lw/sw address              MEMRD  | data read (waits on mem_ready)
// MEMWB  | load writeback             MEMWR  | data write (waits on mem_ready)
// EXEC   | R-type ALU op              ALUWB  | R-type writeback
// BRANCH | beq compare/redirect       ADDIEX | addi ALU op
// ADDIWB | addi writeback             JUMP   | jump redirect
module mips_multicycle_control (
  input  logic                              clk,
  input  logic                              rst_n,
  mips_multicycle_control_if.master         bus
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110;

  state_t      r_state, w_next;
  logic        w_funct_ok;
  logic [2:0]  w_funct_alu;
  logic        w_pc_en, w_ir_write, w_mem_read, w_mem_write, w_iord, w_reg_write;
  logic        w_reg_dst, w_mem_to_reg, w_src_a, w_illegal;
  logic [1:0]  w_src_b, w_pc_src;
  logic [2:0]  w_alu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_alu = ALU_ADD;
    case (bus.funct)
      6'b100000: w_funct_alu = 3'b010;
      6'b100010: w_funct_alu = 3'b110;
      6'b100100: w_funct_alu = 3'b000;
      6'b100101: w_funct_alu = 3'b001;
      6'b101010: w_funct_alu = 3'b111;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_next       = r_state;
    w_pc_en      = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_iord       = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_src_a      = 1'b0;
    w_src_b      = 2'b00;
    w_pc_src     = 2'b00;
    w_alu        = ALU_ADD;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_src_b    = 2'b01;
        w_pc_en    = bus.mem_ready;
        w_ir_write = bus.mem_ready;
        if (bus.mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_src_b = 2'b11;
        w_next  = S_FETCH;
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         if (w_funct_ok) w_next = S_EXEC; else w_illegal = 1'b1;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_src_a = 1'b1;
        w_src_b = 2'b10;
        w_next  = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (bus.mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (bus.mem_ready) w_next = S_FETCH;
      end
      S_EXEC: begin
        w_src_a = 1'b1;
        w_alu   = w_funct_alu;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_src_a  = 1'b1;
        w_alu    = ALU_SUB;
        w_pc_src = 2'b01;
        w_pc_en  = (bus.alu_result == 32'h0);
        w_next   = S_FETCH;
      end
      S_ADDIEX: begin
        w_src_a = 1'b1;
        w_src_b = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        w_pc_src = 2'b10;
        w_pc_en  = 1'b1;
        w_next   = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset silences every strobe asynchronously, not just after the next edge.
  always_comb begin
    bus.pc_en       = rst_n & w_pc_en;
    bus.ir_write    = rst_n & w_ir_write;
    bus.mem_read    = rst_n & w_mem_read;
    bus.mem_write   = rst_n & w_mem_write;
    bus.iord        = rst_n & w_iord;
    bus.reg_write   = rst_n & w_reg_write;
    bus.reg_dst     = rst_n & w_reg_dst;
    bus.mem_to_reg  = rst_n & w_mem_to_reg;
    bus.alu_src_a   = rst_n & w_src_a;
    bus.alu_src_b   = rst_n ? w_src_b : 2'b00;
    bus.pc_src      = rst_n ? w_pc_src : 2'b00;
    bus.alu_control = rst_n ? w_alu : ALU_ADD;
    bus.illegal_op  = rst_n & w_illegal;
    bus.state       = r_state;
  end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: random and directed instructions against a per-instruction cycle model.
module tb_mips_multicycle_control;
  typedef struct packed {
    logic [3:0] st;
    logic       pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, src_a;
    logic [1:0] src_b, pc_src;
    logic [2:0] alu;
    logic       ill;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   track_mw = 0;
  int   seen_mw  = 0;

  out_t eq[$];
  bit   rq[$];

  always #5 clk = ~clk;

  mips_multicycle_control_if bus();
  mips_multicycle_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic out_t obs();
    out_t o;
    o.st = bus.state;         o.pc_en = bus.pc_en;         o.ir_write = bus.ir_write;
    o.mem_read = bus.mem_read; o.mem_write = bus.mem_write; o.iord = bus.iord;
    o.reg_write = bus.reg_write; o.reg_dst = bus.reg_dst;  o.mem_to_reg = bus.mem_to_reg;
    o.src_a = bus.alu_src_a;  o.src_b = bus.alu_src_b;     o.pc_src = bus.pc_src;
    o.alu = bus.alu_control;  o.ill = bus.illegal_op;
    return o;
  endfunction

  function automatic out_t base(input int st);
    out_t o = '0;
    o.st  = 4'(st);
    o.alu = 3'b010;
    return o;
  endfunction

  task automatic check(input string tag, input out_t exp);
    out_t o = obs();
    n_assert++;
    assert (o === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_assert++;
      assert (!(bus.mem_read && bus.mem_write)) else begin
        n_fail++;
        $error("FAIL strobe_overlap: observed rd=%0b wr=%0b expected not both", bus.mem_read, bus.mem_write);
      end
      if (track_mw && bus.mem_write) seen_mw++;
    end
  end

  function automatic bit funct_alu(input logic [5:0] fn, output logic [2:0] alu);
    alu = 3'b010;
    case (fn)
      6'h20: alu = 3'b010;
      6'h22: alu = 3'b110;
      6'h24: alu = 3'b000;
      6'h25: alu = 3'b001;
      6'h2A: alu = 3'b111;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Expected per-cycle behaviour of one instruction, built from its class and wait counts.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] ar,
                       input int fw, input int mw);
    out_t o;
    logic [2:0] alu;
    bit ok_fn = funct_alu(fn, alu);
    bit illegal = !((op == 6'h00 && ok_fn) || op == 6'h23 || op == 6'h2B ||
                    op == 6'h04 || op == 6'h08 || op == 6'h02);
    eq.delete(); rq.delete();
    for (int k = 0; k <= fw; k++) begin
      o = base(0); o.mem_read = 1; o.src_b = 2'b01;
      o.pc_en = (k == fw); o.ir_write = (k == fw);
      eq.push_back(o); rq.push_back(k == fw);
    end
    o = base(1); o.src_b = 2'b11; o.ill = illegal;
    eq.push_back(o); rq.push_back(1'($urandom));
    if (illegal) return;
    case (op)
      6'h23, 6'h2B: begin
        o = base(2); o.src_a = 1; o.src_b = 2'b10;
        eq.push_back(o); rq.push_back(1'($urandom));
        for (int k = 0; k <= mw; k++) begin
          if (op == 6'h23) begin o = base(3); o.mem_read = 1; end
          else begin o = base(5); o.mem_write = 1; end
          o.iord = 1;
          eq.push_back(o); rq.push_back(k == mw);
        end
        if (op == 6'h23) begin
          o = base(4); o.reg_write = 1; o.mem_to_reg = 1;
          eq.push_back(o); rq.push_back(1'($urandom));
        end
      end
      6'h00: begin
        o = base(6); o.src_a = 1; o.alu = alu;
        eq.push_back(o); rq.push_back(1'($urandom));
        o = base(7); o.reg_write = 1; o.reg_dst = 1;
        eq.push_back(o); rq.push_back(1'($urandom));
      end
      6'h04: begin
        o = base(8); o.src_a = 1; o.alu = 3'b110; o.pc_src = 2'b01; o.pc_en = (ar == 0);
        eq.push_back(o); rq.push_back(1'($urandom));
      end
      6'h08: begin
        o = base(9); o.src_a = 1; o.src_b = 2'b10;
        eq.push_back(o); rq.push_back(1'($urandom));
        o = base(10); o.reg_write = 1;
        eq.push_back(o); rq.push_back(1'($urandom));
      end
      default: begin
        o = base(11); o.pc_src = 2'b10; o.pc_en = 1;
        eq.push_back(o); rq.push_back(1'($urandom));
      end
    endcase
  endtask

  // Called at posedge+1 with the DUT in FETCH; leaves it at posedge+1 back in FETCH.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic [31:0] ar, input int fw, input int mw);
    build(op, fn, ar, fw, mw);
    bus.opcode = op; bus.funct = fn; bus.alu_result = ar;
    for (int i = 0; i < eq.size(); i++) begin
      bus.mem_ready = rq[i];
      @(negedge clk);
      check($sformatf("%s_c%0d", name, i), eq[i]);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    out_t o;
    logic [5:0] ops[6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0] op, fn;
    rst_n = 1'b0;
    bus.opcode = '0; bus.funct = '0; bus.alu_result = '0; bus.mem_ready = 1'b0;
    #12;
    check("reset_state", base(0));
    rst_n = 1'b1;
    #1;
    o = base(0); o.mem_read = 1; o.src_b = 2'b01;
    check("fetch_after_release", o);
    @(posedge clk); #1;

    run_instr("add", 6'h00, 6'h20, 32'h0, 0, 0);
    run_instr("lw_wait2", 6'h23, 6'h00, 32'h0, 0, 2);
    run_instr("beq_taken", 6'h04, 6'h00, 32'h0, 0, 0);
    run_instr("beq_not", 6'h04, 6'h00, 32'h4, 0, 0);
    run_instr("sub", 6'h00, 6'h22, 32'h0, 0, 0);
    run_instr("and", 6'h00, 6'h24, 32'h0, 0, 0);
    run_instr("or", 6'h00, 6'h25, 32'h0, 0, 0);
    run_instr("slt", 6'h00, 6'h2A, 32'h0, 0, 0);
    run_instr("bad_funct", 6'h00, 6'h27, 32'h0, 0, 0);
    run_instr("bad_op", 6'h3F, 6'h00, 32'h0, 0, 0);
    run_instr("j", 6'h02, 6'h00, 32'h0, 0, 0);
    run_instr("sw_wait1", 6'h2B, 6'h00, 32'h0, 1, 1);
    run_instr("addi", 6'h08, 6'h00, 32'h0, 0, 0);

    for (int t = 0; t < 80; t++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr($sformatf("rnd%0d", t), op, fn,
                ($urandom_range(0, 1) == 1) ? 32'h0 : $urandom,
                $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Abort a store while it is waiting in MEMWR.
    bus.opcode = 6'h2B; bus.funct = '0; bus.mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.mem_ready = 1'b0;
    o = base(5); o.mem_write = 1; o.iord = 1;
    check("memwr_before_abort", o);
    #2 rst_n = 1'b0;
    #1 check("abort_async", base(0));
    @(posedge clk); #1;
    check("abort_held", base(0));
    track_mw = 1;
    rst_n = 1'b1;
    #1;
    o = base(0); o.mem_read = 1; o.src_b = 2'b01;
    check("fetch_after_abort", o);
    @(posedge clk); #1;
    run_instr("add_after_abort", 6'h00, 6'h20, 32'h0, 0, 0);
    n_assert++;
    assert (seen_mw == 0) else begin
      n_fail++;
      $error("FAIL no_mem_write_after_abort: observed %0d expected 0", seen_mw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
